// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial front end: shifter state encoding and
// the default word width used by the source, the detector top and the bench.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/serial_word_source_if.sv
// Word-side valid/ready handshake feeding the serializer.
interface serial_word_source_if #(
    parameter int WIDTH = serial_pkg::DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/word_hold_reg.sv
// One-entry holding register: captures a word while the shifter is busy and
// releases it when the shifter frees up. A read and a write may share an edge.
module word_hold_reg #(
    parameter int WIDTH = serial_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_full
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else begin
            if (wr_en) begin
                hold_data <= wr_data;
            end
            // A write on the same edge as a read refills the entry.
            if (wr_en) begin
                hold_full <= 1'b1;
            end else if (rd_en) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_word_source.sv
// Parallel-to-serial front end: accepts words over valid/ready and emits one
// bit per bit_en strobe, with a holding register for gapless back-to-back words.
module serial_word_source
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    serial_word_source_if.slave  in_if,
    input  logic                 bit_en,
    output logic                 x,
    output logic                 x_valid,
    output logic                 last_bit,
    output logic                 busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  sh;
    logic [WIDTH-1:0]  sh_shifted;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  hold_data;
    logic              hold_full;

    logic              xfer;
    logic              emit;
    logic              at_last;
    logic              shifter_free;
    logic              load;
    logic              hold_wr;
    logic              hold_rd;
    logic [WIDTH-1:0]  load_data;
    logic              cur_bit;

    assign in_if.in_ready = !hold_full;
    assign xfer           = in_if.in_valid && !hold_full;
    assign busy           = (state_q == SHIFT);

    assign emit         = (state_q == SHIFT) && bit_en;
    assign at_last      = (cnt == CNT_LAST);
    assign shifter_free = (state_q == IDLE) || (emit && at_last);

    // Hold only takes a word when the shifter cannot; a free shifter with an
    // empty hold takes the incoming word directly.
    assign load      = shifter_free && (hold_full || xfer);
    assign hold_rd   = shifter_free && hold_full;
    assign hold_wr   = xfer && !(shifter_free && !hold_full);
    assign load_data = hold_full ? hold_data : in_if.in_data;

    assign cur_bit    = MSB_FIRST ? sh[WIDTH-1] : sh[0];
    assign sh_shifted = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};

    word_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (hold_wr),
        .wr_data   (in_if.in_data),
        .rd_en     (hold_rd),
        .hold_data (hold_data),
        .hold_full (hold_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SHIFT;
        end else if (shifter_free) begin
            state_d = IDLE;
        end
    end

    // On the final-bit edge the outgoing bit is taken from sh before the
    // next word overwrites it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load) begin
            sh  <= load_data;
            cnt <= '0;
        end else if (emit) begin
            sh  <= sh_shifted;
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x        <= 1'b0;
            x_valid  <= 1'b0;
            last_bit <= 1'b0;
        end else begin
            x_valid  <= emit;
            last_bit <= emit && at_last;
            if (emit) begin
                x <= cur_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_source.sv
// Directed bench for serial_word_source: MSB-first and LSB-first instances
// driven from one linear stimulus sequence with hand-computed expectations.
module tb_serial_word_source;
    import serial_pkg::*;

    logic clk;
    logic reset_n;
    logic bit_en;

    logic x_m, xv_m, lb_m, busy_m;
    logic x_l, xv_l, lb_l, busy_l;

    int checks = 0;
    int errors = 0;

    serial_word_source_if #(.WIDTH(8)) m_if ();
    serial_word_source_if #(.WIDTH(8)) l_if ();

    serial_word_source #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_if    (m_if.slave),
        .bit_en   (bit_en),
        .x        (x_m),
        .x_valid  (xv_m),
        .last_bit (lb_m),
        .busy     (busy_m)
    );

    serial_word_source #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_if    (l_if.slave),
        .bit_en   (bit_en),
        .x        (x_l),
        .x_valid  (xv_l),
        .last_bit (lb_l),
        .busy     (busy_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  w;
    logic [15:0] w16;
    logic [3:0]  pat;
    int          n1101;
    logic        prev;

    initial begin
        reset_n       = 1'b0;
        bit_en        = 1'b0;
        m_if.in_valid = 1'b0;
        m_if.in_data  = '0;
        l_if.in_valid = 1'b0;
        l_if.in_data  = '0;

        // reset state
        tick();
        tick();
        chk("rst_x", x_m, 0);
        chk("rst_x_valid", xv_m, 0);
        chk("rst_last_bit", lb_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_in_ready", m_if.in_ready, 1);
        chk("rst_in_ready_l", l_if.in_ready, 1);
        reset_n = 1'b1;
        tick();

        // single word MSB-first, bit_en held high
        w = 8'hB4;
        bit_en = 1'b1;
        m_if.in_valid = 1'b1;
        m_if.in_data  = w;
        tick();
        m_if.in_valid = 1'b0;
        chk("single_load_busy", busy_m, 1);
        chk("single_load_no_bit", xv_m, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("single_xv", xv_m, 1);
            chk("single_x", x_m, w[7-i]);
            chk("single_last", lb_m, (i == 7));
        end
        chk("single_busy_end", busy_m, 0);
        tick();
        chk("single_xv_after", xv_m, 0);
        chk("single_last_after", lb_m, 0);

        // back-to-back words with in_valid held
        w16 = 16'hDD0D;
        pat = '0;
        n1101 = 0;
        m_if.in_valid = 1'b1;
        m_if.in_data  = 8'hDD;
        tick();
        m_if.in_data  = 8'h0D;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) m_if.in_valid = 1'b0;
            chk("b2b_xv", xv_m, 1);
            chk("b2b_x", x_m, w16[15-i]);
            chk("b2b_last", lb_m, (i == 7 || i == 15));
            chk("b2b_in_ready", m_if.in_ready, (i >= 7));
            pat = {pat[2:0], x_m};
            if (i >= 3 && pat == 4'b1101) n1101++;
        end
        chk("b2b_1101_count", n1101, 3);
        tick();
        chk("b2b_xv_after", xv_m, 0);
        chk("b2b_busy_after", busy_m, 0);

        // bit_en every third cycle
        w = 8'hF0;
        prev = 1'b1;
        bit_en = 1'b0;
        m_if.in_valid = 1'b1;
        m_if.in_data  = w;
        tick();
        m_if.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("strobe_gap_xv", xv_m, 0);
            chk("strobe_gap_x", x_m, prev);
            tick();
            chk("strobe_gap_xv", xv_m, 0);
            bit_en = 1'b1;
            tick();
            bit_en = 1'b0;
            chk("strobe_xv", xv_m, 1);
            chk("strobe_x", x_m, w[7-i]);
            chk("strobe_last", lb_m, (i == 7));
            prev = w[7-i];
        end
        tick();
        chk("strobe_hold_x", x_m, 0);
        chk("strobe_busy_end", busy_m, 0);

        // LSB-first instance
        w = 8'h0B;
        bit_en = 1'b1;
        l_if.in_valid = 1'b1;
        l_if.in_data  = w;
        tick();
        l_if.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("lsb_xv", xv_l, 1);
            chk("lsb_x", x_l, w[i]);
            chk("lsb_last", lb_l, (i == 7));
        end
        tick();
        chk("lsb_busy_end", busy_l, 0);

        // new word on the same edge as the last bit, hold empty
        w = 8'h81;
        m_if.in_valid = 1'b1;
        m_if.in_data  = w;
        tick();
        m_if.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("simul_a_x", x_m, w[7-i]);
        end
        m_if.in_valid = 1'b1;
        m_if.in_data  = 8'h6A;
        tick();
        m_if.in_valid = 1'b0;
        chk("simul_a_last_x", x_m, 1);
        chk("simul_a_last", lb_m, 1);
        chk("simul_busy", busy_m, 1);
        chk("simul_in_ready", m_if.in_ready, 1);
        w = 8'h6A;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("simul_b_xv", xv_m, 1);
            chk("simul_b_x", x_m, w[7-i]);
            chk("simul_b_last", lb_m, (i == 7));
            chk("simul_b_in_ready", m_if.in_ready, 1);
        end
        tick();

        // reset mid-word with a second word waiting in hold
        w = 8'hD5;
        m_if.in_valid = 1'b1;
        m_if.in_data  = w;
        tick();
        m_if.in_data  = 8'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) m_if.in_valid = 1'b0;
            chk("rstmid_x", x_m, w[7-i]);
        end
        chk("rstmid_in_ready_full", m_if.in_ready, 0);
        reset_n = 1'b0;
        #1;
        chk("rstmid_xv", xv_m, 0);
        chk("rstmid_busy", busy_m, 0);
        chk("rstmid_in_ready", m_if.in_ready, 1);
        chk("rstmid_x0", x_m, 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid_idle_busy", busy_m, 0);
            chk("rstmid_idle_xv", xv_m, 0);
        end
        w = 8'h3C;
        m_if.in_valid = 1'b1;
        m_if.in_data  = w;
        tick();
        m_if.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rstmid_new_xv", xv_m, 1);
            chk("rstmid_new_x", x_m, w[7-i]);
            chk("rstmid_new_last", lb_m, (i == 7));
        end
        tick();
        chk("rstmid_new_busy_end", busy_m, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_source.md
# serial_word_source

Parallel-to-serial front end for the bit-serial sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them as a bit stream, one bit per `bit_en` strobe, on the detector's `x` input. A one-word holding register lets back-to-back words stream with no bubble between frames.

## Interface
- `WIDTH`, default 8: word width in bits, must be ≥ 2.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  reset, asynchronous, active-low; one clock, no other clock domain.
- `in_data`  in  WIDTH  word to serialize.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `bit_en`  in  1  bit-rate strobe; one output bit per asserted cycle.
- `x`  out  1  serial bit to the detector (registered).
- `x_valid`  out  1  one-cycle pulse, `x` was updated this cycle.
- `last_bit`  out  1  asserted with `x_valid` on the final bit of a word.
- `busy`  out  1  shifter holds a word in progress.

## Operation
- Storage: shift register `sh` (WIDTH), bit counter `cnt` (0..WIDTH-1), holding register `hold` plus flag `hold_full`.
- States: IDLE (shifter empty), SHIFT (word in progress). `busy` = (state == SHIFT).
- Handshake: a word transfers on an edge with `in_valid && in_ready`. `in_ready` = !hold_full, derived combinationally from the register. `in_data` must stay stable while `in_valid` is high and `in_ready` is low.
- Load rule, evaluated each edge. "Shifter free" means state IDLE, or SHIFT with `bit_en` and `cnt == WIDTH-1`.
  - Shifter free and hold_full: `sh` <= `hold`, clear `hold_full`. If the input transfers on the same edge, the new word goes into `hold`.
  - Shifter free, hold empty, input transfers: bypass, so `sh` <= `in_data`.
  - Shifter busy and input transfers: `hold` <= `in_data`, set `hold_full`.
  - Any load: `cnt` <= 0, state <= SHIFT.
  - Shifter free and nothing to load: state <= IDLE.
- Bit emission: on an edge where state == SHIFT and `bit_en`:
  - `x` <= current bit, which is `sh[WIDTH-1]` if MSB_FIRST, else `sh[0]`.
  - `sh` shifts toward the output end, zero fill.
  - `cnt` increments, `x_valid` <= 1.
  - `last_bit` <= (cnt == WIDTH-1).
- On all other edges: `x_valid` <= 0 and `last_bit` <= 0; `x` holds its last value.
- `bit_en` in IDLE is ignored. No bit is emitted on the edge that loads from IDLE.
- Reset (asynchronous, any time, including mid-word):
  - state IDLE; `x`, `x_valid`, `last_bit`, `busy`, `hold_full`, `cnt`, `sh` all 0.
  - `in_ready` = 1.
  - Words in flight or in `hold` are discarded; no partial frame resumes.

## Timing
- Latency: word accepted at edge N in IDLE with hold empty. The first `x_valid` occurs at the first edge after N with `bit_en` high, so one cycle minimum with `bit_en` held high.
- Throughput with `bit_en` tied high: one bit per cycle, no gap between words when `hold` is filled before the last bit.
- The last bit of word k and the first bit of word k+1 occur on consecutive `bit_en` edges.
- `in_ready` falls the cycle after `hold` fills. It rises the cycle after `hold` moves into `sh`.
- Bits appear at the detector input one `bit_en` edge after they become current in `sh`.

## Structure
- Shared package `serial_pkg`: state enum (IDLE=1'b0, SHIFT=1'b1) and the default WIDTH constant, reused by the bench and the detector top.
- Natural sub-module: `word_hold_reg`, the one-entry valid/ready holding register with `hold_full` flag. The rest (FSM, counter, shifter) stays in the top module.

## Test plan
- Reset mid-word: assert `reset_n`=0 after bit 3 of 8'hD5 -> `x_valid`=0, `busy`=0, `in_ready`=1 immediately; the next word starts again from its first bit.
- Single word: WIDTH=8, MSB_FIRST=1, `bit_en`=1, send 8'hB4 -> `x` = 1,0,1,1,0,1,0,0 on 8 consecutive `x_valid` pulses; `last_bit` only on the 8th; `busy` drops the cycle after.
- Back-to-back: send 8'hDD then 8'h0D while `in_valid` is held -> 16 contiguous bits, no gap. `in_ready`=0 from the cycle after word 2 is held until word 2 loads. The detector sees the 1101 patterns at the expected bit positions.
- Strobed rate: `bit_en` every 3rd cycle, send 8'hF0 -> exactly 8 `x_valid` pulses, spaced 3 cycles apart. `x` holds its value between pulses.
- LSB-first: MSB_FIRST=0, send 8'h0B -> `x` = 1,1,0,1,0,0,0,0.
- Simultaneous events: a new word arrives on the same edge as the last bit, with `hold` empty -> bypass load; the first bit of the new word appears on the next `bit_en` edge and `hold_full` stays 0.
